// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: PC, imem requests, in-order prefetch FIFO, redirect flush
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect raises sticky fetch_fault)
module inst_fetch #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        fetch_fault
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
   localparam logic [CW:0]   DEPTH   = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc;
   logic [31:0]   resp_pc;
   logic [31:0]   mem_inst [FIFO_DEPTH];
   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic          fault;

   logic [CW:0]   inflight;
   logic          fire;
   logic          push;
   logic          pop;
   logic          redir_fault;
   logic [31:0]   redir_target;

`ifdef FETCH_ALIGN_CHK_EN
   assign redir_fault  = |redirect_pc[1:0];
   assign redir_target = redirect_pc;
`else
   assign redir_fault  = 1'b0;
   assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif

   // Words still to land in the FIFO are counted against its space so a push never overflows.
   assign inflight  = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop_cnt};
   assign imem_req  = !rst && !redirect_valid && !fault &&
                      (outstanding < MAX_OUT) && (inflight < DEPTH);
   assign imem_addr = pc;
   assign fire      = imem_req && imem_gnt;

   assign inst_valid  = (count != '0);
   assign inst        = mem_inst[rd_ptr];
   assign inst_pc     = mem_pc[rd_ptr];
   assign fetch_fault = fault;

   assign push = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
   assign pop  = inst_valid && inst_ready && !redirect_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         fault       <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_inst[i] <= '0;
            mem_pc[i]   <= '0;
         end
      end else if (redirect_valid) begin
         // Everything already issued (minus a response landing now) becomes stale and is dropped.
         pc          <= redir_target;
         resp_pc     <= redir_target;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= outstanding - CW'(imem_rvalid);
         drop_cnt    <= outstanding - CW'(imem_rvalid);
         fault       <= redir_fault;
      end else begin
         if (fire)
            pc <= pc + 32'd4;
         outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid);
         if (imem_rvalid && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CW'(1);
         if (push) begin
            mem_inst[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= resp_pc;
            wr_ptr           <= wr_ptr + AW'(1);
            resp_pc          <= resp_pc + 32'd4;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
// Honours FETCH_ALIGN_CHK_EN to select the misaligned-redirect expectations.
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        fetch_fault;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          bad_data = 0;
   bit          resp_en = 1'b1;
   logic [31:0] mq[$];
   logic [31:0] fired[$];
   logic [31:0] got[$];
   logic [31:0] last;
   logic [31:0] a0;

   inst_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive the memory response for this cycle and let combinational outputs settle.
   task automatic settle();
      if (resp_en && mq.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mdata(mq[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      #1;
   endtask

   task automatic advance();
      if (!rst) begin
         if (imem_req && imem_gnt) begin
            mq.push_back(imem_addr);
            fired.push_back(imem_addr);
         end
         if (imem_rvalid) void'(mq.pop_front());
         if (inst_valid && inst_ready && !redirect_valid) begin
            got.push_back(inst_pc);
            if (inst !== mdata(inst_pc)) bad_data++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         advance();
      end
   endtask

   task automatic seq_check(input string tag, input logic [31:0] start, input int n);
      if (got.size() < n)
         chk({tag, "_len"}, got.size(), n);
      else
         for (int i = 0; i < n; i++)
            chk(tag, got[i], start + 32'(4 * i));
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req"}, imem_req, 0);
      chk({tag, "_valid"}, inst_valid, 0);
      chk({tag, "_inst"}, inst, 0);
      chk({tag, "_pc"}, inst_pc, 0);
      chk({tag, "_fault"}, fetch_fault, 0);
   endtask

   initial begin
      @(negedge clk);
      settle();
      reset_checks("rst");
      advance();

      // 1: free-running sequential fetch
      imem_gnt = 1'b1;
      inst_ready = 1'b1;
      rst = 1'b0;
      settle();
      chk("t1_first_req", imem_req, 1);
      chk("t1_first_addr", imem_addr, 32'h0);
      advance();
      run(10);
      if (fired.size() < 4) chk("t1_fired_len", fired.size(), 4);
      else for (int i = 0; i < 4; i++) chk("t1_addr", fired[i], 32'(4 * i));
      seq_check("t1_pc", 32'h0, 6);

      // 2: decode stall fills FIFO and throttles requests
      last = got[$];
      inst_ready = 1'b0;
      run(10);
      settle();
      chk("t2_req_off", imem_req, 0);
      chk("t2_valid", inst_valid, 1);
      chk("t2_head_pc", inst_pc, last + 32'd4);
      advance();
      got.delete();
      inst_ready = 1'b1;
      run(12);
      seq_check("t2_pc", last + 32'd4, 8);

      // 3: reset mid-run, two outstanding, redirect before responses
      rst = 1'b1;
      mq.delete();
      settle();
      reset_checks("rst_mid");
      advance();
      rst = 1'b0;
      resp_en = 1'b0;
      fired.delete();
      got.delete();
      run(2);
      settle();
      chk("t3_cap", imem_req, 0);
      advance();
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      settle();
      chk("t3_redir_req", imem_req, 0);
      advance();
      redirect_valid = 1'b0;
      resp_en = 1'b1;
      fired.delete();
      run(10);
      if (fired.size() < 1) chk("t3_fired_len", fired.size(), 1);
      else chk("t3_first_addr", fired[0], 32'h100);
      seq_check("t3_pc", 32'h100, 3);

      // 4: redirect coinciding with a response and a pop
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      settle();
      chk("t4_pre_valid", inst_valid, 1);
      advance();
      redirect_valid = 1'b0;
      got.delete();
      settle();
      chk("t4_flushed", inst_valid, 0);
      chk("t4_req", imem_req, 1);
      chk("t4_addr", imem_addr, 32'h300);
      advance();
      run(8);
      seq_check("t4_pc", 32'h300, 4);

      // 5: grant withheld
      imem_gnt = 1'b0;
      settle();
      a0 = imem_addr;
      advance();
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("t5_req", imem_req, 1);
         chk("t5_addr", imem_addr, a0);
         advance();
      end
      imem_gnt = 1'b1;
      fired.delete();
      run(1);
      if (fired.size() < 1) chk("t5_fired_len", fired.size(), 1);
      else chk("t5_resume_addr", fired[0], a0);
      run(4);

      // 6: misaligned redirect
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      settle();
      advance();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t6_fault", fetch_fault, 1);
         chk("t6_req_held", imem_req, 0);
         advance();
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      settle();
      advance();
      redirect_valid = 1'b0;
      got.delete();
      settle();
      chk("t6_fault_clr", fetch_fault, 0);
      chk("t6_req", imem_req, 1);
      chk("t6_addr", imem_addr, 32'h200);
      advance();
      run(8);
      seq_check("t6_pc", 32'h200, 4);
`else
      got.delete();
      settle();
      chk("t6_fault", fetch_fault, 0);
      chk("t6_req", imem_req, 1);
      chk("t6_addr", imem_addr, 32'h100);
      advance();
      run(8);
      seq_check("t6_pc", 32'h100, 4);
`endif

      chk("data", bad_data, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
